vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
//  - Pixel-timing source for the video path. Produces the raster scan position (DrawX/DrawY), the
//    sync pulses and the blanking signal that drive the VGA DAC.
//  - DrawX/DrawY feed the color mapper, which returns VGA_R/G/B for that same pixel.
//  - frame_start gives the game logic (player, ghosts, coins) one update strobe per frame.
// PARAMETERS
//  H_VISIBLE 640  visible pixels per line
//  H_FP      16   horizontal front porch (pixels)
//  H_SYNC    96   horizontal sync width (pixels)
//  H_BP      48   horizontal back porch (pixels); line total = 800
//  V_VISIBLE 480  visible lines per frame
//  V_FP      10   vertical front porch (lines)
//  V_SYNC    2    vertical sync width (lines)
//  V_BP      33   vertical back porch (lines); frame total = 525
// PORTS
//  Clk          in   1   system clock; all state updates on its rising edge
//  Reset        in   1   synchronous, active-high reset
//  VGA_CLK      out  1   pixel clock to the DAC
//  VGA_HS       out  1   horizontal sync, active low
//  VGA_VS       out  1   vertical sync, active low
//  VGA_BLANK_N  out  1   1 = visible pixel, 0 = blanking
//  VGA_SYNC_N   out  1   tied 0 (no sync-on-green)
//  DrawX        out  10  current column, 0..799
//  DrawY        out  10  current row, 0..524
//  frame_start  out  1   one-Clk pulse at the start of each frame
// BEHAVIOUR
//  - Pixel tick `pix_en`: asserted every Clk in the base build (see CONFIGURATION).
//  - Counters hc and vc are 10-bit registers and are output directly as DrawX/DrawY.
//  - On pix_en:
//      - hc = (hc==H_TOTAL-1) ? 0 : hc+1
//      - on hc wrap: vc = (vc==V_TOTAL-1) ? 0 : vc+1
//      - H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP; V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP.
//  - VGA_HS, VGA_VS and VGA_BLANK_N are registered and computed from the next-state counters,
//    so they are aligned with DrawX/DrawY in the same cycle (zero relative skew):
//      - VGA_HS = 0 iff H_VISIBLE+H_FP <= hc < H_VISIBLE+H_FP+H_SYNC (656..751)
//      - VGA_VS = 0 iff V_VISIBLE+V_FP <= vc < V_VISIBLE+V_FP+V_SYNC (490..491)
//      - VGA_BLANK_N = 1 iff hc < H_VISIBLE && vc < V_VISIBLE
//  - frame_start: registered; high for exactly one Clk, in the cycle where (hc,vc) first becomes
//    (0,0) after (799,524). It is never high on two consecutive Clk cycles.
//  - Reset values: hc=0, vc=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, frame_start=0, VGA_CLK=0.
//  - First cycle after Reset deasserts:
//      - counters hold (0,0); counting resumes on the next pix_en
//      - no frame_start is issued for this post-reset frame
//      - outputs stay at their reset values until the first pix_en registers the decoded values.
//  - Reset mid-line or mid-frame: takes effect immediately, no partial-line completion.
//  - VGA_SYNC_N is constant 0.
//  - Arithmetic: all comparisons are unsigned 10-bit; the parameter sums must be <= 1023.
// CONFIGURATION
//  - VGA_PIXEL_DIV2_EN undefined:
//      - pix_en = 1 every Clk (Clk is the 25 MHz pixel clock)
//      - VGA_CLK = Clk passed through
//      - frame = 420000 Clk
//  - VGA_PIXEL_DIV2_EN defined:
//      - a toggle flop (reset 0) divides the 50 MHz Clk; pix_en = toggle==1
//      - VGA_CLK = toggle (registered)
//      - counters and registered outputs change only on pix_en cycles
//      - frame_start still lasts one Clk; frame = 840000 Clk
// TESTING
//  1. Reset 3 cycles, release -> DrawX=0, DrawY=0, HS=1, VS=1, BLANK_N=0; after 1st tick BLANK_N=1.
//  2. Run 800 ticks -> DrawX wraps 799->0 while DrawY goes 0->1; HS low exactly for DrawX 656..751
//     (96 ticks).
//  3. Run 420000 ticks -> one frame_start pulse, at (0,0); VS low for exactly 1600 ticks (rows
//     490..491); BLANK_N low for all DrawY>=480.
//  4. Assert Reset at DrawX=300, DrawY=200 -> next cycle all outputs at reset values;
//     no frame_start.
//  5. VGA_PIXEL_DIV2_EN defined -> DrawX increments every 2nd Clk; VGA_CLK toggles each Clk;
//     frame_start stays 1 Clk wide; frame = 840000 Clk.
//  6. Check across 2 frames -> VGA_SYNC_N=0 always; frame_start period = 420000 Clk (base build).

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA 640x480 raster timing: scan counters, registered syncs/blanking, per-frame strobe.
// Define VGA_PIXEL_DIV2_EN to derive the pixel tick from a 50 MHz Clk via a divide-by-2 toggle.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic       Clk,
  input  logic       Reset,
  output logic       VGA_CLK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_MAX      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] H_SYNC_END = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] V_SYNC_END = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic       pix_en;
  logic [9:0] hc, vc;
  logic [9:0] hc_next, vc_next;
  logic       h_wrap, v_wrap;

`ifdef VGA_PIXEL_DIV2_EN
  logic toggle;

  always_ff @(posedge Clk) begin
    if (Reset) toggle <= 1'b0;
    else       toggle <= ~toggle;
  end

  assign pix_en  = toggle;
  assign VGA_CLK = toggle;
`else
  assign pix_en  = 1'b1;
  assign VGA_CLK = Clk;
`endif

  assign h_wrap  = (hc == H_MAX);
  assign v_wrap  = (vc == V_MAX);
  assign hc_next = h_wrap ? 10'd0 : hc + 10'd1;
  assign vc_next = h_wrap ? (v_wrap ? 10'd0 : vc + 10'd1) : vc;

  // Syncs and blanking decode the next-state counters so they land together with DrawX/DrawY.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hc          <= 10'd0;
      vc          <= 10'd0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en && h_wrap && v_wrap;
      if (pix_en) begin
        hc          <= hc_next;
        vc          <= vc_next;
        VGA_HS      <= !((hc_next >= H_SYNC_BEG) && (hc_next < H_SYNC_END));
        VGA_VS      <= !((vc_next >= V_SYNC_BEG) && (vc_next < V_SYNC_END));
        VGA_BLANK_N <= (hc_next < H_VIS) && (vc_next < V_VIS);
      end
    end
  end

  assign DrawX      = hc;
  assign DrawY      = vc;
  assign VGA_SYNC_N = 1'b0;

endmodule
